// File: rtl/reg_file_banked.sv
// ---------------------------------------------------------------------------
// reg_file_banked
//
// Banked special/general register file for the small CPU core. Holds the
// INDF/TMR0/PCL/STATUS/FSR/PORTA/PORTB/OPTION registers plus general RAM.
// File locations 0x07..(2^(AW-1)-1) are common RAM shared by every bank.
// The upper half of the direct space is banked RAM, NBANK banks deep.
// INDF (address 0) is a true indirect access through FSR.
//
// Compile-time option:
//   TMR0_PRESCALER_EN - when defined, OPTION[3]=PSA and OPTION[2:0]=PS drive an
//                       8-bit prescaler in front of TMR0. When undefined, every
//                       tmr0_inc pulse counts, and OPTION is stored but unused.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   f_wr, f_adrs          file write strobe and direct file address
//   f_in_data             write data
//   f_out_data            combinational read data
//   PCL1                  current PC low byte, returned on PCL reads
//   C_en/DC_en/Z_en       ALU flag update enables
//   C_new/DC_new/Z_new    ALU flag values
//   SLEEP, CLRWDT, wdtmr  power-down / watchdog events (TO_N/PD_N)
//   tmr0_inc              TMR0 count event
//   opt_wr                OPTION instruction strobe (loads f_in_data[5:0])
//   porta_in, portb_in    port pin inputs (returned on PORTA/PORTB reads)
//   PORTA, PORTB          port output latches
//   FSR                   file select register
//   C                     carry flag
//   PCL_wr                direct write to PCL this cycle
//   tmr0_ovf              one-cycle pulse after TMR0 wraps to zero
// ---------------------------------------------------------------------------
module reg_file_banked #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int NBANK = 4,
    parameter int PAW   = 4,
    parameter int BW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_wr,
    input  logic [AW-1:0]     f_adrs,
    input  logic [DW-1:0]     f_in_data,
    output logic [DW-1:0]     f_out_data,
    input  logic [DW-1:0]     PCL1,
    input  logic              C_en,
    input  logic              DC_en,
    input  logic              Z_en,
    input  logic              C_new,
    input  logic              DC_new,
    input  logic              Z_new,
    input  logic              SLEEP,
    input  logic              CLRWDT,
    input  logic              wdtmr,
    input  logic              tmr0_inc,
    input  logic              opt_wr,
    input  logic [PAW-1:0]    porta_in,
    input  logic [DW-1:0]     portb_in,
    output logic [PAW-1:0]    PORTA,
    output logic [DW-1:0]     PORTB,
    output logic [AW+BW-1:0]  FSR,
    output logic              C,
    output logic              PCL_wr,
    output logic              tmr0_ovf
);

    localparam int FW   = AW + BW;        // FSR width
    localparam int HALF = 2 ** (AW - 1);  // words per half of the direct space

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [FW-1:0]  fsr_q;
    logic [DW-1:0]  tmr0_q;
    logic [2:0]     pa_q;
    logic           to_n_q;
    logic           pd_n_q;
    logic           z_q;
    logic           dc_q;
    logic           c_q;
    logic [PAW-1:0] porta_q;
    logic [DW-1:0]  portb_q;
    logic [5:0]     option_q;
    logic [1:0]     inhibit_q;   // TMR0 counting suppressed while non-zero
    logic           ovf_q;

    logic [DW-1:0]  common_ram [HALF];
    logic [DW-1:0]  bank_ram   [NBANK*HALF];

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic [FW-1:0]    ea;
    logic [AW-1:0]    ea_lo;
    logic [BW-1:0]    ea_bank;
    logic [AW-2:0]    ram_off;
    logic             ram_hi;
    logic             is_ram;
    logic             wr_tmr0;
    logic             wr_status;
    logic             wr_fsr;
    logic             wr_porta;
    logic             wr_portb;

    // Address 0 goes indirect: the whole FSR (bank bits included) is the
    // effective address. Direct accesses borrow only the bank bits.
    assign ea      = (f_adrs == '0) ? fsr_q : {fsr_q[FW-1:AW], f_adrs};
    assign ea_lo   = ea[AW-1:0];
    assign ea_bank = ea[FW-1:AW];
    assign ram_hi  = ea_lo[AW-1];
    assign ram_off = ea_lo[AW-2:0];
    assign is_ram  = ram_hi | (ea_lo >= AW'(7));

    // ea_lo == 0 only happens when FSR points back at INDF; it matches no
    // write enable below, so such a write is dropped.
    assign wr_tmr0   = f_wr & (ea_lo == AW'(1));
    assign wr_status = f_wr & (ea_lo == AW'(3));
    assign wr_fsr    = f_wr & (ea_lo == AW'(4));
    assign wr_porta  = f_wr & (ea_lo == AW'(5));
    assign wr_portb  = f_wr & (ea_lo == AW'(6));

    assign PCL_wr = f_wr & (f_adrs == AW'(2));

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    always_comb begin
        f_out_data = '0;
        case (ea_lo)
            AW'(0):  f_out_data = '0;
            AW'(1):  f_out_data = tmr0_q;
            AW'(2):  f_out_data = PCL1;
            AW'(3):  f_out_data = DW'({pa_q, to_n_q, pd_n_q, z_q, dc_q, c_q});
            AW'(4):  f_out_data = {{(DW-FW){1'b1}}, fsr_q};
            AW'(5):  f_out_data = DW'(porta_in);
            AW'(6):  f_out_data = portb_in;
            default: begin
                if (ram_hi) f_out_data = bank_ram[{ea_bank, ram_off}];
                else        f_out_data = common_ram[ram_off];
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // TMR0 count qualification
    // -----------------------------------------------------------------------
    logic tmr0_qual;

`ifdef TMR0_PRESCALER_EN
    logic [7:0] presc_q;
    logic [7:0] presc_lim;
    logic       psa;
    logic       cnt_evt;

    assign psa       = option_q[3];
    // Terminal count 2^(PS+1)-1: PS=0 -> 1, PS=7 -> 255.
    assign presc_lim = 8'hFF >> (3'd7 - option_q[2:0]);
    assign cnt_evt   = tmr0_inc & (inhibit_q == 2'd0) & ~wr_tmr0;
    assign tmr0_qual = psa ? cnt_evt : (cnt_evt & (presc_q == presc_lim));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (wr_tmr0) begin
            presc_q <= '0;
        end else if (cnt_evt && !psa) begin
            presc_q <= (presc_q == presc_lim) ? 8'd0 : presc_q + 8'd1;
        end
    end

    logic unused_option;
    assign unused_option = ^option_q[5:4];
`else
    assign tmr0_qual = tmr0_inc;

    logic unused_option;
    assign unused_option = ^option_q;
`endif

    // -----------------------------------------------------------------------
    // TMR0, write-inhibit window and overflow pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr0_q    <= '0;
            inhibit_q <= 2'd0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (wr_tmr0) begin
                // A write drops any same-cycle count and blocks the next two.
                tmr0_q    <= f_in_data;
                inhibit_q <= 2'd2;
            end else if (inhibit_q != 2'd0) begin
                inhibit_q <= inhibit_q - 2'd1;
            end else if (tmr0_qual) begin
                tmr0_q <= tmr0_q + DW'(1);
                ovf_q  <= &tmr0_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Special registers with reset
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fsr_q    <= '0;
            pa_q     <= 3'd0;
            to_n_q   <= 1'b1;
            pd_n_q   <= 1'b1;
            porta_q  <= '0;
            portb_q  <= '0;
            option_q <= 6'h3F;
        end else begin
            if (wr_fsr)    fsr_q   <= f_in_data[FW-1:0];
            if (wr_status) pa_q    <= f_in_data[7:5];
            if (wr_porta)  porta_q <= f_in_data[PAW-1:0];
            if (wr_portb)  portb_q <= f_in_data;
            if (opt_wr)    option_q <= f_in_data[5:0];

            if (CLRWDT) begin
                to_n_q <= 1'b1;
                pd_n_q <= 1'b1;
            end else if (SLEEP) begin
                to_n_q <= 1'b1;
                pd_n_q <= 1'b0;
            end else if (wdtmr) begin
                to_n_q <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // ALU flags (not reset). Any active ALU enable blocks a STATUS write from
    // touching all three flags; only the enabled flags then change.
    // -----------------------------------------------------------------------
    logic alu_any;
    assign alu_any = C_en | DC_en | Z_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (alu_any) begin
                if (C_en)  c_q  <= C_new;
                if (DC_en) dc_q <= DC_new;
                if (Z_en)  z_q  <= Z_new;
            end else if (wr_status) begin
                z_q  <= f_in_data[2];
                dc_q <= f_in_data[1];
                c_q  <= f_in_data[0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // General RAM (not reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && f_wr && is_ram) begin
            if (ram_hi) bank_ram[{ea_bank, ram_off}] <= f_in_data;
            else        common_ram[ram_off]          <= f_in_data;
        end
    end

    assign PORTA    = porta_q;
    assign PORTB    = portb_q;
    assign FSR      = fsr_q;
    assign C        = c_q;
    assign tmr0_ovf = ovf_q;

endmodule
